// File: rtl/rpsc_pkg.sv
// Shared types and stage indices for the RPSC tube-supply power sequencer.
package rpsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UP_CMD   = 3'd1,
    ST_UP_DWELL = 3'd2,
    ST_RUN      = 3'd3,
    ST_DOWN     = 3'd4,
    ST_FAULT    = 3'd5
  } seq_state_t;

  typedef enum logic [2:0] {
    FC_NONE          = 3'd0,
    FC_PERM_LOST     = 3'd1,
    FC_FB_TIMEOUT    = 3'd2,
    FC_FB_DROP       = 3'd3,
    FC_START_NO_PERM = 3'd4
  } fault_code_t;

  localparam logic [1:0] STG_FAN   = 2'd0;
  localparam logic [1:0] STG_CA    = 2'd1;
  localparam logic [1:0] STG_G1    = 2'd2;
  localparam logic [1:0] STG_ANODE = 2'd3;

endpackage

// File: rtl/rpsc_hv_sequencer_if.sv
// Control/status bundle between the supervisory logic (master) and the sequencer (slave).
interface rpsc_hv_sequencer_if;
  logic       start_req;
  logic       stop_req;
  logic       fault_clr;
  logic [3:0] perm;
  logic [3:0] fb;
  logic [3:0] on_cmd;
  logic       running;
  logic       busy;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] stage;

  modport master (
    output start_req, stop_req, fault_clr, perm, fb,
    input  on_cmd, running, busy, fault, fault_code, stage
  );

  modport slave (
    input  start_req, stop_req, fault_clr, perm, fb,
    output on_cmd, running, busy, fault, fault_code, stage
  );
endinterface

// File: rtl/rpsc_stage_timer.sv
// Loadable down-counter shared by the dwell, timeout, gap and cooldown waits.
// Expired is flagged while the count reads zero, so a load of N waits N+1 cycles.
module rpsc_stage_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/rpsc_hv_sequencer.sv
// FAN -> CA -> G1 -> Anode power sequencer with reverse ramp-down and latched fault handling.
// Optional fan run-on after CA off: define RPSC_FAN_COOLDOWN_EN.
//
// state    | meaning
// IDLE     | all stages off, waiting for start_req
// UP_CMD   | on_cmd[stage] asserted, waiting for fb[stage] or timeout
// UP_DWELL | feedback confirmed, settling before the next stage
// RUN      | all four stages energised and monitored
// DOWN     | dropping stages in reverse order with a gap between each
// FAULT    | HV stages dropped, fault code latched until fault_clr
module rpsc_hv_sequencer
  import rpsc_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES      = 1000,
  parameter int unsigned FB_TIMEOUT_CYCLES = 50000,
  parameter int unsigned DOWN_GAP_CYCLES   = 500,
  parameter int unsigned COOLDOWN_CYCLES   = 100000,
  parameter int          CNT_W             = 20
) (
  input logic               clk,
  input logic               reset,
  rpsc_hv_sequencer_if.slave sif
);

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  if (DWELL_CYCLES >= CNT_LIMIT || FB_TIMEOUT_CYCLES >= CNT_LIMIT ||
      DOWN_GAP_CYCLES >= CNT_LIMIT || COOLDOWN_CYCLES >= CNT_LIMIT) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured cycle counts");
  end

  seq_state_t  r_state,  w_state_nx;
  logic [3:0]  r_on_cmd, w_on_nx;
  logic [1:0]  r_stage,  w_stage_nx;
  logic        r_fault,  w_fault_nx;
  fault_code_t r_fault_code, w_code_nx;
  logic        r_running, w_running_nx;
  logic        r_busy,    w_busy_nx;

  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_expired;

  logic        w_go_fault;
  fault_code_t w_cause;
  logic        w_enter_down;
  logic [1:0]  w_dn_stage;
  logic        w_perm_lost;
  logic        w_fb_drop;

  rpsc_stage_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_expired)
  );

  assign w_perm_lost = |(r_on_cmd & ~sif.perm);
  assign w_fb_drop   = |(r_on_cmd & ~sif.fb);

  always_comb begin
    w_state_nx   = r_state;
    w_on_nx      = r_on_cmd;
    w_stage_nx   = r_stage;
    w_fault_nx   = r_fault;
    w_code_nx    = r_fault_code;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_go_fault   = 1'b0;
    w_cause      = FC_NONE;
    w_enter_down = 1'b0;
    w_dn_stage   = r_stage;

    case (r_state)
      ST_IDLE: begin
        if (sif.start_req && !sif.stop_req) begin
          if (&sif.perm) begin
            w_state_nx       = ST_UP_CMD;
            w_stage_nx       = STG_FAN;
            w_on_nx[STG_FAN] = 1'b1;
            w_tmr_load       = 1'b1;
            w_tmr_val        = CNT_W'(FB_TIMEOUT_CYCLES);
          end else begin
            w_go_fault = 1'b1;
            w_cause    = FC_START_NO_PERM;
          end
        end
      end
      ST_UP_CMD: begin
        if (sif.stop_req) begin
          w_enter_down = 1'b1;
        end else if (sif.fb[r_stage]) begin
          w_state_nx = ST_UP_DWELL;
          w_tmr_load = 1'b1;
          w_tmr_val  = CNT_W'(DWELL_CYCLES);
        end else if (w_tmr_expired) begin
          w_go_fault = 1'b1;
          w_cause    = FC_FB_TIMEOUT;
        end
      end
      ST_UP_DWELL: begin
        if (sif.stop_req) begin
          w_enter_down = 1'b1;
        end else if (w_tmr_expired) begin
          if (r_stage == STG_ANODE) begin
            w_state_nx = ST_RUN;
          end else begin
            w_state_nx                 = ST_UP_CMD;
            w_stage_nx                 = 2'(r_stage + 2'd1);
            w_on_nx[2'(r_stage + 2'd1)] = 1'b1;
            w_tmr_load                 = 1'b1;
            w_tmr_val                  = CNT_W'(FB_TIMEOUT_CYCLES);
          end
        end
      end
      ST_RUN: begin
        if (w_fb_drop) begin
          w_go_fault = 1'b1;
          w_cause    = FC_FB_DROP;
        end else if (sif.stop_req) begin
          w_enter_down = 1'b1;
          w_dn_stage   = STG_ANODE;
        end
      end
      ST_DOWN: begin
        if (w_tmr_expired) begin
          if (r_stage == STG_FAN) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_enter_down = 1'b1;
            w_dn_stage   = 2'(r_stage - 2'd1);
          end
        end
      end
      ST_FAULT: begin
`ifdef RPSC_FAN_COOLDOWN_EN
        if (r_on_cmd[STG_FAN] && (!sif.perm[STG_FAN] || w_tmr_expired)) begin
          w_on_nx[STG_FAN] = 1'b0;
        end
`endif
        if (sif.fault_clr && (sif.fb == 4'h0) && (r_on_cmd == 4'h0)) begin
          w_state_nx = ST_IDLE;
          w_fault_nx = 1'b0;
          w_code_nx  = FC_NONE;
          w_stage_nx = STG_FAN;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    if (w_enter_down) begin
      w_state_nx          = ST_DOWN;
      w_stage_nx          = w_dn_stage;
      w_on_nx[w_dn_stage] = 1'b0;
      w_tmr_load          = 1'b1;
      w_tmr_val           = CNT_W'(DOWN_GAP_CYCLES);
`ifdef RPSC_FAN_COOLDOWN_EN
      // The gap after CA drops doubles as the fan run-on
      if (w_dn_stage == STG_CA) w_tmr_val = CNT_W'(COOLDOWN_CYCLES);
`endif
    end

    if ((r_state != ST_IDLE) && (r_state != ST_FAULT) && w_perm_lost) begin
      w_go_fault = 1'b1;
      w_cause    = FC_PERM_LOST;
    end

    if (w_go_fault) begin
      w_state_nx         = ST_FAULT;
      w_stage_nx         = r_stage;
      w_fault_nx         = 1'b1;
      if (r_fault_code == FC_NONE) w_code_nx = w_cause;
      w_on_nx[STG_CA]    = 1'b0;
      w_on_nx[STG_G1]    = 1'b0;
      w_on_nx[STG_ANODE] = 1'b0;
`ifdef RPSC_FAN_COOLDOWN_EN
      w_on_nx[STG_FAN]   = r_on_cmd[STG_FAN] & sif.perm[STG_FAN];
      w_tmr_load         = 1'b1;
      w_tmr_val          = CNT_W'(COOLDOWN_CYCLES);
`else
      w_on_nx[STG_FAN]   = 1'b0;
`endif
    end

    w_running_nx = (w_state_nx == ST_RUN);
    w_busy_nx    = (w_state_nx == ST_UP_CMD) || (w_state_nx == ST_UP_DWELL) ||
                   (w_state_nx == ST_DOWN);
`ifdef RPSC_FAN_COOLDOWN_EN
    if ((w_state_nx == ST_FAULT) && w_on_nx[STG_FAN]) w_busy_nx = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_on_cmd     <= 4'h0;
      r_stage      <= STG_FAN;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
      r_running    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_on_cmd     <= w_on_nx;
      r_stage      <= w_stage_nx;
      r_fault      <= w_fault_nx;
      r_fault_code <= w_code_nx;
      r_running    <= w_running_nx;
      r_busy       <= w_busy_nx;
    end
  end

  assign sif.on_cmd     = r_on_cmd;
  assign sif.running    = r_running;
  assign sif.busy       = r_busy;
  assign sif.fault      = r_fault;
  assign sif.fault_code = r_fault_code;
  assign sif.stage      = r_stage;

endmodule

// File: doc/rpsc_hv_sequencer.md
Name: rpsc_hv_sequencer

Overview:
Power-sequencing controller for the RPSC tube supply chain FAN -> CA (cathode/heater) -> G1 (grid) -> Anode.
- Drives the four ON commands that the card-10 latches capture, gated by each stage's permissive.
- Powers up in order, with per-stage feedback timeout and settle dwell.
- Powers down in reverse order.
- On any permissive loss or feedback fault, drops all HV stages at once and holds a latched fault code.

Parameters:
DWELL_CYCLES, 1000, settle time after stage feedback confirms, before the next stage is commanded
FB_TIMEOUT_CYCLES, 50000, maximum cycles from stage command to feedback high
DOWN_GAP_CYCLES, 500, gap between stage drops during orderly ramp-down
COOLDOWN_CYCLES, 100000, fan run-on after CA off (optional feature only)
CNT_W, 20, width of the shared stage timer; must hold the largest cycle parameter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_req  in  1  single-cycle pulse; begin power-up
stop_req  in  1  single-cycle pulse; begin orderly power-down
fault_clr  in  1  single-cycle pulse; clear latched fault
perm  in  4  permissives [0]=FAN [1]=CA [2]=G1 [3]=Anode
fb  in  4  ON feedback, same bit order, already synchronised
on_cmd  out  4  ON commands, same bit order
running  out  1  high only in RUN
busy  out  1  high in any UP or DOWN state
fault  out  1  latched fault present
fault_code  out  3  0 none, 1 perm lost, 2 fb timeout, 3 fb dropped in RUN, 4 start without perms
stage  out  2  index of the stage currently being acted on

Behaviour:
- Reset (async assert, sync release): state IDLE; on_cmd=0; running=0; busy=0; fault=0; fault_code=0; stage=0; timer=0.
- All outputs are registered.
- States: IDLE, UP_CMD, UP_DWELL, RUN, DOWN, FAULT.
- IDLE + start_req:
  - all perm high -> UP_CMD, stage=0.
  - otherwise -> FAULT with code 4.
- UP_CMD:
  - on entry set on_cmd[stage] (lower bits stay set); timer=FB_TIMEOUT_CYCLES.
  - fb[stage] high -> UP_DWELL, timer=DWELL_CYCLES.
  - timer reaches 0 first -> FAULT, code 2.
- UP_DWELL: timer reaches 0 -> stage<3 ? UP_CMD with stage+1 : RUN.
- RUN:
  - fb bit dropping on any energised stage -> FAULT, code 3.
  - stop_req -> DOWN, stage=3.
- DOWN:
  - clear on_cmd[stage]; wait DOWN_GAP_CYCLES; decrement stage.
  - after stage 0 is cleared -> IDLE.
  - stop_req is also accepted in UP_CMD/UP_DWELL: enter DOWN at the current stage.
- Permissive check, every cycle outside IDLE/FAULT: perm[i]==0 for any stage i with on_cmd[i]==1 -> FAULT, code 1. This has priority over every other transition in the same cycle.
- FAULT entry:
  - on_cmd[3:1] cleared in the same cycle the fault is registered (next edge).
  - on_cmd[0] (FAN) also cleared unless the optional feature is enabled.
  - fault=1; fault_code is captured once, first cause wins.
- FAULT exit: fault_clr clears fault/code -> IDLE only when fb==0 and on_cmd==0; otherwise fault_clr is ignored.
- start_req outside IDLE is ignored.
- stop_req in IDLE/FAULT is ignored.
- start_req and stop_req in the same cycle: stop wins (no start).
- Timer: loads N and counts down one per cycle; expiry is the cycle it reads 0, so the total wait is N+1 cycles from load.

Optional Feature:
RPSC_FAN_COOLDOWN_EN
- Defined:
  - FAN (on_cmd[0]) stays on COOLDOWN_CYCLES after CA is cleared, in both DOWN and FAULT.
  - busy stays high during cooldown; the fault_clr exit condition also requires cooldown to have elapsed.
  - FAN still drops immediately if perm[0] is lost.
- Undefined: FAN drops with the other stages, as in the base behaviour.

Decomposition:
- Package rpsc_pkg:
  - seq_state_t enum.
  - fault_code_t enum (3-bit).
  - stage index constants STG_FAN=0, STG_CA=1, STG_G1=2, STG_ANODE=3.
- Sub-module rpsc_stage_timer: loadable CNT_W down-counter with load, value and expired flag. It is reused for the dwell, timeout, gap and cooldown waits.

Test Plan:
- Nominal power-up: perm=4'hF, DWELL=4, fb follows on_cmd after 2 cycles -> on_cmd steps 1,3,7,F; running=1 at cycle 4×(2+1+5)+1 ±1.
- Feedback timeout: FB_TIMEOUT=10, fb[2] held 0 -> on_cmd=0 exactly 11 cycles after on_cmd[2] rises; fault_code=2.
- Permissive loss: in RUN drop perm[1] -> next edge on_cmd=0 (FAN=0 without the macro), fault_code=1; a following fault_clr with fb≠0 is ignored.
- Orderly stop: in RUN pulse stop_req, DOWN_GAP=3 -> on_cmd F,7,3,1,0 at 4-cycle spacing; then IDLE, busy=0.
- Simultaneous events: start_req and stop_req together in IDLE -> stays IDLE; start with perm=4'h7 -> FAULT code 4.
- Reset mid-UP_DWELL with stage=2: on_cmd=0 asynchronously; after release, a new start sequences again from FAN.
